// File: rtl/key_matrix_scan_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
package key_matrix_scan_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Key indices (row*4+col) of the keys wired as direction buttons.
    localparam int KEY_UP    = 1;
    localparam int KEY_LEFT  = 4;
    localparam int KEY_RIGHT = 6;
    localparam int KEY_DOWN  = 9;

    typedef logic [NUM_KEYS-1:0]         keyMap_t;
    typedef logic [$clog2(NUM_KEYS)-1:0] keyIndex_t;

    typedef enum logic {
        EV_IDLE,
        EV_PENDING
    } evState_t;

    // Descending scan so the lowest set index is the one left standing.
    function automatic keyIndex_t lowestSetIndex(input keyMap_t map);
        keyIndex_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (map[i]) begin
                idx = keyIndex_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// Press-event handshake between the keypad scanner and its consumer.
interface key_matrix_scan_if;
    import key_matrix_scan_pkg::*;

    keyIndex_t keyCode;
    logic      keyValid;
    logic      keyAck;
    logic      overrun;

    modport master (
        output keyCode,
        output keyValid,
        output overrun,
        input  keyAck
    );

    modport slave (
        input  keyCode,
        input  keyValid,
        input  overrun,
        output keyAck
    );

endinterface

// File: rtl/key_debounce.sv
// Frame-level debouncer: a frame becomes the key state only after DEBOUNCE
// identical consecutive frames, and the newly pressed keys are reported then.
module key_debounce
    import key_matrix_scan_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  keyMap_t frame,
    input  logic    frameDone,
    output keyMap_t keyState,
    output keyMap_t pressSet
);

    localparam int STABLE_W = $clog2(DEBOUNCE + 1);
    typedef logic [STABLE_W-1:0] stable_t;
    localparam stable_t STABLE_MAX = stable_t'(DEBOUNCE);

    keyMap_t prevFrame;
    stable_t stableCount;
    logic    loadEn;

    // A differing frame restarts the run at one, since it is itself the first sighting.
    always_ff @(posedge clk) begin
        if (reset) begin
            prevFrame   <= '0;
            stableCount <= '0;
        end else if (frameDone) begin
            if (frame == prevFrame) begin
                if (stableCount != STABLE_MAX) begin
                    stableCount <= stableCount + stable_t'(1);
                end
            end else begin
                prevFrame   <= frame;
                stableCount <= stable_t'(1);
            end
        end
    end

    assign loadEn   = (stableCount == STABLE_MAX) && (prevFrame != keyState);
    assign pressSet = loadEn ? (prevFrame & ~keyState) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            keyState <= '0;
        end else if (loadEn) begin
            keyState <= prevFrame;
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: strobes rows, samples synchronized columns into frames,
// debounces them and raises one acknowledged press event at a time.
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_ROWS-1:0] KEY_ROW,
    input  logic [NUM_COLS-1:0] KEY_COL,
    output keyMap_t             keyState,
    key_matrix_scan_if.master   keyEvent,
    output logic                btnUp,
    output logic                btnDown,
    output logic                btnLeft,
    output logic                btnRight
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    typedef logic [DWELL_W-1:0]          dwell_t;
    typedef logic [$clog2(NUM_ROWS)-1:0] row_t;
    localparam dwell_t DWELL_LAST = dwell_t'(SCAN_DIV - 1);
    localparam row_t   ROW_LAST   = row_t'(NUM_ROWS - 1);

    logic [NUM_COLS-1:0] colMeta;
    logic [NUM_COLS-1:0] colSync;
    row_t                row;
    dwell_t              dwell;
    logic                sampleNow;
    keyMap_t             frame;
    logic                frameDone;
    keyMap_t             pressSet;

    evState_t            evState;
    evState_t            evNext;
    logic                newEvent;
    logic                keyValidInt;
    logic                loadCode;
    logic                setOverrun;
    keyIndex_t           keyCodeReg;
    logic                overrunReg;

    // Idle level of the pulled-up columns, so reset does not look like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            colMeta <= '1;
            colSync <= '1;
        end else begin
            colMeta <= KEY_COL;
            colSync <= colMeta;
        end
    end

    assign sampleNow = (dwell == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            row   <= '0;
            dwell <= '0;
        end else if (sampleNow) begin
            dwell <= '0;
            row   <= (row == ROW_LAST) ? '0 : row + row_t'(1);
        end else begin
            dwell <= dwell + dwell_t'(1);
        end
    end

    always_comb begin
        KEY_ROW      = '1;
        KEY_ROW[row] = 1'b0;
    end

    // frameDone trails the last row's sample so the debouncer sees the whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame     <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= sampleNow && (row == ROW_LAST);
            if (sampleNow) begin
                frame[row*NUM_COLS +: NUM_COLS] <= ~colSync;
            end
        end
    end

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) debounceInst (
        .clk       (clk),
        .reset     (reset),
        .frame     (frame),
        .frameDone (frameDone),
        .keyState  (keyState),
        .pressSet  (pressSet)
    );

    assign newEvent = |pressSet;

    always_ff @(posedge clk) begin
        if (reset) begin
            evState <= EV_IDLE;
        end else begin
            evState <= evNext;
        end
    end

    always_comb begin
        evNext = evState;
        case (evState)
            EV_IDLE:    if (newEvent) evNext = EV_PENDING;
            EV_PENDING: if (!newEvent && keyEvent.keyAck) evNext = EV_IDLE;
            default:    evNext = EV_IDLE;
        endcase
    end

    // An acknowledge in the same cycle as a new press frees the slot for it.
    always_comb begin
        keyValidInt = (evState == EV_PENDING);
        loadCode    = newEvent && (!keyValidInt || keyEvent.keyAck);
        setOverrun  = newEvent && keyValidInt && !keyEvent.keyAck;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keyCodeReg <= '0;
            overrunReg <= 1'b0;
        end else begin
            if (loadCode) begin
                keyCodeReg <= lowestSetIndex(pressSet);
            end
            if (setOverrun) begin
                overrunReg <= 1'b1;
            end
        end
    end

    assign keyEvent.keyCode  = keyCodeReg;
    assign keyEvent.keyValid = keyValidInt;
    assign keyEvent.overrun  = overrunReg;

    assign btnUp    = keyState[KEY_UP];
    assign btnDown  = keyState[KEY_DOWN];
    assign btnLeft  = keyState[KEY_LEFT];
    assign btnRight = keyState[KEY_RIGHT];

endmodule

// File: doc/key_matrix_scan.md
KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1024, clk cycles each row is driven before its columns are sampled (min 2).
REQ-002 SHALL provide parameter DEBOUNCE, default 4, consecutive identical full-matrix frames required to accept a new key state (min 1).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 KEY_ROW  out  4  row strobes to 4x4 keypad, one-hot active-low.
REQ-006 KEY_COL  in  4  column returns, active-low (external pull-ups); asynchronous to clk.
REQ-007 keyState  out  16  debounced pressed map, bit = row*4+col, 1 = pressed.
REQ-008 keyCode  out  4  index of the pending press event.
REQ-009 keyValid  out  1  press event pending; held until acknowledged.
REQ-010 keyAck  in  1  consumer accepts the pending event.
REQ-011 overrun  out  1  sticky: a press event was dropped.
REQ-012 btnUp, btnDown, btnLeft, btnRight  out  1 each  levels = keyState bits 1, 9, 4, 6.

Function
REQ-013 KEY_COL SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Row counter SHALL cycle 0,1,2,3,0...; KEY_ROW drives only the current row low.
REQ-015 Dwell counter SHALL count 0..SCAN_DIV-1 per row; synchronized columns sampled on count SCAN_DIV-1, then the row advances on the next cycle.
REQ-016 Sampled bits SHALL be inverted (pressed = 1) and stored at frame[row*4 +: 4].
REQ-017 After row 3 is sampled, the completed frame SHALL be compared with the previous frame: equal -> stable counter +1 (saturating at DEBOUNCE); different -> stable counter = 1 and previous frame replaced.
REQ-018 When stable counter reaches DEBOUNCE and frame differs from keyState, keyState SHALL load the frame on the following cycle.
REQ-019 Press set SHALL be newFrame AND NOT oldKeyState; releases generate no event.
REQ-020 If the press set is non-zero, keyCode SHALL be the lowest set index; higher simultaneous presses are discarded without overrun.
REQ-021 Event with keyValid=0, or keyValid=1 and keyAck=1 same cycle: keyCode loads, keyValid=1 next cycle.
REQ-022 Event with keyValid=1 and keyAck=0: event dropped, keyCode unchanged, overrun set.
REQ-023 keyAck with no new event SHALL clear keyValid next cycle; keyAck while keyValid=0 is ignored.
REQ-024 Latency: stable press to keyValid SHALL be DEBOUNCE full frames plus at most 2 cycles after the frame's final sample.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 reset SHALL set: row=0, KEY_ROW=4'b1110, dwell=0, frame/previous frame=0, stable counter=0, keyState=0, keyCode=0, keyValid=0, overrun=0, synchronizer flops=4'b1111.
REQ-027 reset mid-frame SHALL discard the partial frame and any pending event; scanning restarts at row 0 the cycle after reset deasserts.

Structure
REQ-028 Shared package SHALL hold NUM_ROWS=4, NUM_COLS=4 and the direction key indices (UP=1, LEFT=4, RIGHT=6, DOWN=9).
REQ-029 Debounce/compare logic SHALL be one sub-module, key_debounce (frame in, frameDone strobe, keyState and press set out); scanning and event logic stay in key_matrix_scan.

Verification (SCAN_DIV=4, DEBOUNCE=2 unless stated)
REQ-030 Reset, no keys: KEY_ROW sequence 1110,1101,1011,0111 each 4 cycles, repeating; keyValid=0, keyState=0.
REQ-031 Model holds key 6 (row1,col2) pressed -> keyState=16'h0040, btnRight=1, keyValid=1 with keyCode=6 within 2 frames + 2 cycles; keyAck -> keyValid=0 next cycle.
REQ-032 Key 9 bounces on alternate frames for 6 frames then holds -> exactly one event keyCode=9; no event during bounce.
REQ-033 Keys 4 and 1 stable same frame -> single event keyCode=1; keyState=16'h0012; overrun=0.
REQ-034 Key 1 pressed without ack, then key 4 pressed -> keyCode stays 1, overrun=1; ack then release/press key 4 -> keyCode=4.
REQ-035 Assert reset with keyValid=1 mid-row 2 -> all outputs at reset values next cycle; scan resumes at row 0.
